lsu_align_unit: RTL and testbench

//  Load/store unit between EX result and the 32-bit byte-lane data BRAM. Accepts one access per

---
 rtl/lsu_align_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_align_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_unit
// Description : Load/store alignment unit sitting between the EX stage and a
//               32-bit byte-lane data BRAM with 1-cycle read latency.
//               Accepts one access per request handshake, splits accesses that
//               straddle a word boundary into two aligned word accesses,
//               builds byte write enables and lane-shifted store data, and
//               merges / sign- or zero-extends load data. Returns a held,
//               handshaked response.
// Ports       : clk_i, rst_i                      clock, sync active-high reset
//               req_valid_i/req_ready_o           request handshake
//               req_we_i, req_op_i, req_addr_i,
//               req_wdata_i                       access description
//               rsp_valid_o/rsp_ready_i           response handshake
//               rsp_rdata_o, rsp_err_o            load result / error flag
//               ram_en_o, ram_we_o, ram_addr_o,
//               ram_wdata_o, ram_rdata_i          BRAM port
// Revision    : 1.0  initial release
// ============================================================================
module lsu_align_unit #(
    parameter int ADDR_W      = 14,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_op_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC0 = 3'd1;
    localparam logic [2:0] S_ACC1 = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        state;
    logic              we_q;
    logic [2:0]        op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       w0_q;

    // ------------------------------------------------------------------
    // Legality check on the incoming request (decided in the accept cycle)
    // ------------------------------------------------------------------
    logic in_illegal;
    logic in_misalign;
    logic in_err;

    always_comb begin
        in_illegal = (req_op_i == 3'b011) || (req_op_i[2:1] == 2'b11)
                     || (req_we_i && req_op_i[2]);
        case (req_op_i[1:0])
            2'b01:   in_misalign = req_addr_i[0];
            2'b10:   in_misalign = (req_addr_i[1:0] != 2'b00);
            default: in_misalign = 1'b0;
        endcase
        in_err = in_illegal || (!MISALIGN_EN && in_misalign);
    end

    // ------------------------------------------------------------------
    // Decode of the registered access
    // ------------------------------------------------------------------
    logic [1:0]        offset;
    logic [3:0]        size_mask;
    logic [7:0]        byte_mask;
    logic              split;
    logic [4:0]        shamt;
    logic [ADDR_W-1:0] word0;
    logic [ADDR_W-1:0] word1;
    logic [63:0]       store_lanes;

    always_comb begin
        offset = addr_q[1:0];
        case (op_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        byte_mask   = {4'b0000, size_mask} << offset;
        // Any enabled byte beyond lane 3 means the access spills into word1.
        split       = |byte_mask[7:4];
        shamt       = {offset, 3'b000};
        word0       = addr_q[ADDR_W+1:2];
        // Natural ADDR_W-bit wrap takes the top word over to word 0.
        word1       = word0 + {{(ADDR_W-1){1'b0}}, 1'b1};
        store_lanes = {32'h0, wdata_q} << shamt;
    end

    // ------------------------------------------------------------------
    // Load merge: in CAP the live RAM word is the last one read.
    // ------------------------------------------------------------------
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [63:0] merged;
    logic [31:0] merged_lo;
    logic [31:0] load_result;

    always_comb begin
        lo_word   = split ? w0_q : ram_rdata_i;
        hi_word   = split ? ram_rdata_i : 32'h0;
        merged    = {hi_word, lo_word} >> shamt;
        merged_lo = merged[31:0];
        case (op_q[1:0])
            2'b00: load_result = op_q[2] ? {24'h0, merged_lo[7:0]}
                                         : {{24{merged_lo[7]}}, merged_lo[7:0]};
            2'b01: load_result = op_q[2] ? {16'h0, merged_lo[15:0]}
                                         : {{16{merged_lo[15]}}, merged_lo[15:0]};
            default: load_result = merged_lo;
        endcase
    end

    // ------------------------------------------------------------------
    // BRAM port; enables are gated by reset so an abandoned access never
    // reaches the RAM in the reset cycle.
    // ------------------------------------------------------------------
    logic acc_active;
    logic acc_second;

    always_comb begin
        acc_active  = ((state == S_ACC0) || (state == S_ACC1)) && !rst_i;
        acc_second  = (state == S_ACC1);
        ram_en_o    = acc_active;
        ram_we_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (acc_active) begin
            ram_addr_o = acc_second ? word1 : word0;
            if (we_q) begin
                ram_we_o    = acc_second ? byte_mask[7:4] : byte_mask[3:0];
                ram_wdata_o = acc_second ? store_lanes[63:32] : store_lanes[31:0];
            end
        end
    end

    assign req_ready_o = (state == S_IDLE) && !rst_i;
    assign rsp_valid_o = (state == S_RESP);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            op_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            w0_q        <= 32'h0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        op_q    <= req_op_i;
                        addr_q  <= req_addr_i[ADDR_W+1:0];
                        wdata_q <= req_wdata_i;
                        if (in_err) begin
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= 32'hFFFF_FFFF;
                            state       <= S_RESP;
                        end else begin
                            state <= S_ACC0;
                        end
                    end
                end
                S_ACC0: begin
                    if (split) begin
                        state <= S_ACC1;
                    end else if (we_q) begin
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= 32'h0;
                        state       <= S_RESP;
                    end else begin
                        state <= S_CAP;
                    end
                end
                S_ACC1: begin
                    if (we_q) begin
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= 32'h0;
                        state       <= S_RESP;
                    end else begin
                        // Read data of the word0 access arrives now.
                        w0_q  <= ram_rdata_i;
                        state <= S_CAP;
                    end
                end
                S_CAP: begin
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= load_result;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address bits above the BRAM range and the shifted-out half of the
    // merge are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{req_addr_i, merged[63:32]};

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_align_unit
// Description : Directed self-checking bench for lsu_align_unit. Drives one
//               instance with misaligned splitting enabled (backed by a BRAM
//               model) and one with it disabled.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_align_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rsp_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        v1, v2;

    logic        r1_ready, p1_valid, p1_err, m1_en;
    logic [31:0] p1_rdata, m1_wdata, m1_rdata;
    logic [3:0]  m1_we;
    logic [13:0] m1_addr;

    logic        r2_ready, p2_valid, p2_err, m2_en;
    logic [31:0] p2_rdata, m2_wdata, m2_rdata;
    logic [3:0]  m2_we;
    logic [13:0] m2_addr;
    assign m2_rdata = 32'h0;

    lsu_align_unit #(.ADDR_W(14), .MISALIGN_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v1), .req_ready_o(r1_ready), .req_we_i(req_we),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(p1_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(p1_rdata), .rsp_err_o(p1_err),
        .ram_en_o(m1_en), .ram_we_o(m1_we), .ram_addr_o(m1_addr),
        .ram_wdata_o(m1_wdata), .ram_rdata_i(m1_rdata)
    );

    lsu_align_unit #(.ADDR_W(14), .MISALIGN_EN(1'b0)) dut_na (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v2), .req_ready_o(r2_ready), .req_we_i(req_we),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(p2_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(p2_rdata), .rsp_err_o(p2_err),
        .ram_en_o(m2_en), .ram_we_o(m2_we), .ram_addr_o(m2_addr),
        .ram_wdata_o(m2_wdata), .ram_rdata_i(m2_rdata)
    );

    // BRAM model: byte-lane writes, 1-cycle registered read.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (m1_en) begin
            for (int b = 0; b < 4; b++)
                if (m1_we[b]) mem[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
            m1_rdata <= mem[m1_addr];
        end
    end

    // Observation mux for the instance under test.
    int          sel;
    logic        s_ready, s_valid, s_err, s_en;
    logic [31:0] s_rdata, s_wdata, s_addr;
    logic [3:0]  s_we;
    always_comb begin
        s_ready = (sel == 2) ? r2_ready : r1_ready;
        s_valid = (sel == 2) ? p2_valid : p1_valid;
        s_err   = (sel == 2) ? p2_err   : p1_err;
        s_rdata = (sel == 2) ? p2_rdata : p1_rdata;
        s_en    = (sel == 2) ? m2_en    : m1_en;
        s_we    = (sel == 2) ? m2_we    : m1_we;
        s_addr  = (sel == 2) ? {18'h0, m2_addr} : {18'h0, m1_addr};
        s_wdata = (sel == 2) ? m2_wdata : m1_wdata;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0]  a_we    [0:7];
    logic [31:0] a_addr  [0:7];
    logic [31:0] a_wdata [0:7];
    int          n_acc;

    // One full request/response transaction; latency counted in cycles after
    // the accept cycle.
    task automatic do_req(input int which, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, output int lat,
                          output logic [31:0] rdata, output logic err);
        logic done;
        n_acc = 0;
        sel   = which;
        lat   = 0;
        done  = 1'b0;
        @(negedge clk);
        req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        if (which == 2) v2 = 1'b1; else v1 = 1'b1;
        chk("req_ready_idle", {31'h0, s_ready}, 32'h1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            if (s_en) begin
                if (n_acc < 8) begin
                    a_we[n_acc] = s_we; a_addr[n_acc] = s_addr; a_wdata[n_acc] = s_wdata;
                end
                n_acc++;
            end
            if (s_valid) begin
                lat  = k;
                done = 1'b1;
            end
        end
        if (!done) chk("rsp_timeout", 32'h0, 32'h1);
        rdata = s_rdata;
        err   = s_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'h0, s_valid}, 32'h1);
            chk("stall_rdata", s_rdata, rdata);
            chk("stall_ready", {31'h0, s_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic chk_acc(input string tag, input int i, input logic [31:0] addr,
                           input logic [3:0] we, input logic [31:0] wdata);
        chk({tag, "_addr"}, a_addr[i], addr);
        chk({tag, "_we"}, {28'h0, a_we[i]}, {28'h0, we});
        chk({tag, "_wdata"}, a_wdata[i], wdata);
    endtask

    task automatic chk_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input int exp_lat, input logic [31:0] exp_data);
        int lat; logic [31:0] rd; logic er;
        do_req(1, 1'b0, op, addr, 32'h0, 0, lat, rd, er);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, rd, exp_data);
        chk({tag, "_err"}, {31'h0, er}, 32'h0);
    endtask

    initial begin
        int lat; logic [31:0] rd; logic er;
        rst = 1'b1; rsp_ready = 1'b0; v1 = 1'b0; v2 = 1'b0; sel = 1;
        req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, r1_ready}, 32'h0);
        chk("rst_valid", {31'h0, p1_valid}, 32'h0);
        chk("rst_err", {31'h0, p1_err}, 32'h0);
        chk("rst_rdata", p1_rdata, 32'h0);
        chk("rst_en", {31'h0, m1_en}, 32'h0);
        chk("rst_we", {28'h0, m1_we}, 32'h0);
        chk("rst_addr", {18'h0, m1_addr}, 32'h0);
        chk("rst_wdata", m1_wdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, r1_ready}, 32'h1);

        // Aligned store / load
        do_req(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, lat, rd, er);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_nacc", 32'(n_acc), 32'd1);
        chk_acc("sw", 0, 32'h4, 4'b1111, 32'hDEADBEEF);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err", {31'h0, er}, 32'h0);

        do_req(1, 1'b0, 3'b010, 32'h10, 32'h0, 5, lat, rd, er);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_err", {31'h0, er}, 32'h0);
        chk("lw_we", {28'h0, a_we[0]}, 32'h0);

        // Byte store into lane 3, then sub-word loads with extension
        do_req(1, 1'b1, 3'b000, 32'h13, 32'h12345680, 0, lat, rd, er);
        chk("sb_lat", 32'(lat), 32'd2);
        chk_acc("sb", 0, 32'h4, 4'b1000, 32'h80000000);
        chk_load("lb13", 3'b000, 32'h13, 3, 32'hFFFFFF80);
        chk_load("lbu13", 3'b100, 32'h13, 3, 32'h00000080);
        chk_load("lh12", 3'b001, 32'h12, 3, 32'hFFFF80AD);
        chk_load("lhu12", 3'b101, 32'h12, 3, 32'h000080AD);
        chk_load("lb10", 3'b000, 32'h10, 3, 32'hFFFFFFEF);

        // Split word store / loads across words 3 and 4
        do_req(1, 1'b1, 3'b010, 32'h0E, 32'h11223344, 0, lat, rd, er);
        chk("ssw_lat", 32'(lat), 32'd3);
        chk("ssw_nacc", 32'(n_acc), 32'd2);
        chk_acc("ssw0", 0, 32'h3, 4'b1100, 32'h33440000);
        chk_acc("ssw1", 1, 32'h4, 4'b0011, 32'h00001122);
        chk_load("slw", 3'b010, 32'h0E, 4, 32'h11223344);
        chk_load("slhu", 3'b101, 32'h0F, 4, 32'h00002233);

        // Split halfword store wrapping from the top word to word 0
        do_req(1, 1'b1, 3'b001, 32'hFFFF, 32'h0000ABCD, 0, lat, rd, er);
        chk("wrap_lat", 32'(lat), 32'd3);
        chk_acc("wrap0", 0, 32'h3FFF, 4'b1000, 32'hCD000000);
        chk_acc("wrap1", 1, 32'h0, 4'b0001, 32'h000000AB);
        chk_load("wrap_lhu", 3'b101, 32'hFFFF, 4, 32'h0000ABCD);

        // Illegal ops
        do_req(1, 1'b0, 3'b011, 32'h10, 32'h0, 0, lat, rd, er);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", {31'h0, er}, 32'h1);
        chk("ill_data", rd, 32'hFFFFFFFF);
        chk("ill_nacc", 32'(n_acc), 32'd0);
        do_req(1, 1'b1, 3'b100, 32'h10, 32'h0, 0, lat, rd, er);
        chk("ill_st_err", {31'h0, er}, 32'h1);
        chk("ill_st_nacc", 32'(n_acc), 32'd0);

        // Instance without misaligned splitting
        do_req(2, 1'b0, 3'b010, 32'h02, 32'h0, 0, lat, rd, er);
        chk("na_lat", 32'(lat), 32'd1);
        chk("na_err", {31'h0, er}, 32'h1);
        chk("na_data", rd, 32'hFFFFFFFF);
        chk("na_nacc", 32'(n_acc), 32'd0);
        do_req(2, 1'b0, 3'b010, 32'h04, 32'h0, 0, lat, rd, er);
        chk("na_ok_lat", 32'(lat), 32'd3);
        chk("na_ok_err", {31'h0, er}, 32'h0);
        chk("na_ok_nacc", 32'(n_acc), 32'd1);
        chk("na_ok_addr", a_addr[0], 32'h1);

        // Reset during the second half of a split store
        sel = 1;
        @(negedge clk);
        req_we = 1'b1; req_op = 3'b010; req_addr = 32'h0E; req_wdata = 32'hAABBCCDD;
        v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        chk("rs_acc0_en", {31'h0, m1_en}, 32'h1);
        chk("rs_acc0_we", {28'h0, m1_we}, 32'hC);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rs_en", {31'h0, m1_en}, 32'h0);
        chk("rs_we", {28'h0, m1_we}, 32'h0);
        chk("rs_ready", {31'h0, r1_ready}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rs_ready_after", {31'h0, r1_ready}, 32'h1);
        chk("rs_valid_after", {31'h0, p1_valid}, 32'h0);
        chk("rs_en_after", {31'h0, m1_en}, 32'h0);
        chk("rs_word3", {16'h0, mem[3][31:16]}, 32'h0000CCDD);
        chk("rs_word4", mem[4], 32'h80AD1122);
        chk_load("rs_lw", 3'b010, 32'h10, 3, 32'h80AD1122);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
